// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: gathers one UART frame, feeds the FFT core,
// then streams the real outputs back out. Optional: SEQ_TIMEOUT_EN.
module fft_frame_sequencer #(
    parameter int FFT_SIZE    = 16,
    parameter int WORD_SIZE   = 16,
    parameter int DATA_LENGTH = 8,
    parameter int RX_TIMEOUT  = 86800,
    parameter int FFT_TIMEOUT = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_rx_valid,
    input  logic [DATA_LENGTH-1:0]        i_rx_byte,
    output logic                          o_fft_rst,
    output logic                          o_fft_valid,
    output logic [DATA_LENGTH-1:0]        o_fft_byte,
    input  logic                          i_fft_done,
    input  logic [FFT_SIZE*WORD_SIZE-1:0] i_fft_re,
    output logic                          o_tx_start,
    output logic [DATA_LENGTH-1:0]        o_tx_byte,
    input  logic                          i_tx_done,
    output logic                          o_busy,
    output logic                          o_frame_done,
    output logic                          o_overrun,
    output logic                          o_error
);

    localparam int IDX_W = $clog2(FFT_SIZE);
    localparam int CNT_W = $clog2(FFT_SIZE + 1);
    localparam int TXI_W = $clog2(2 * FFT_SIZE);

    localparam logic [IDX_W-1:0] LD_LAST = IDX_W'(FFT_SIZE - 1);
    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(FFT_SIZE - 1);
    localparam logic [TXI_W-1:0] TX_LAST = TXI_W'(2 * FFT_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_LOAD,
        S_WAIT_FFT,
        S_SEND,
        S_WAIT_TX
    } state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              rx_cnt_q, rx_cnt_d;
    logic [IDX_W-1:0]              ld_idx_q, ld_idx_d;
    logic [TXI_W-1:0]              tx_idx_q, tx_idx_d;
    logic                          overrun_q, overrun_d;
    logic                          done_q, done_d;
    logic                          frame_we;
    logic [IDX_W-1:0]              frame_waddr;
    logic                          snap_we;
    logic [DATA_LENGTH-1:0]        frame_q [FFT_SIZE];
    logic [FFT_SIZE*WORD_SIZE-1:0] snap_q;
    logic                          tx_phase;

`ifdef SEQ_TIMEOUT_EN
    localparam int TMAX = (RX_TIMEOUT > FFT_TIMEOUT) ?
                          RX_TIMEOUT : FFT_TIMEOUT;
    localparam int TMR_W = $clog2(TMAX + 1);
    localparam logic [TMR_W-1:0] RX_TO_LAST  = TMR_W'(RX_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] FFT_TO_LAST = TMR_W'(FFT_TIMEOUT - 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             error_q, error_d;

    // Idle-gap timer and sticky abort flag.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            tmr_q   <= '0;
            error_q <= 1'b0;
        end else begin
            tmr_q   <= tmr_d;
            error_q <= error_d;
        end
    end

    assign o_error = error_q;
`else
    logic [31:0] unused_timeouts;
    assign unused_timeouts = RX_TIMEOUT ^ FFT_TIMEOUT;
    assign o_error = 1'b0;
`endif

    // Next-state logic: frame collection, FFT handoff, byte-serial TX.
    always_comb begin
        state_d     = state_q;
        rx_cnt_d    = rx_cnt_q;
        ld_idx_d    = ld_idx_q;
        tx_idx_d    = tx_idx_q;
        overrun_d   = overrun_q;
        done_d      = 1'b0;
        frame_we    = 1'b0;
        frame_waddr = rx_cnt_q[IDX_W-1:0];
        snap_we     = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        tmr_d       = tmr_q;
        error_d     = error_q;
`endif
        unique case (state_q)
            S_IDLE: begin
`ifdef SEQ_TIMEOUT_EN
                tmr_d = '0;
`endif
                if (i_rx_valid) begin
                    frame_we    = 1'b1;
                    frame_waddr = '0;
                    rx_cnt_d    = CNT_W'(1);
                    state_d     = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (i_rx_valid) begin
                    frame_we = 1'b1;
                    rx_cnt_d = rx_cnt_q + 1'b1;
`ifdef SEQ_TIMEOUT_EN
                    tmr_d    = '0;
`endif
                    if (rx_cnt_q == RX_LAST) begin
                        ld_idx_d = '0;
                        state_d  = S_LOAD;
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                else if (tmr_q == RX_TO_LAST) begin
                    rx_cnt_d = '0;
                    tmr_d    = '0;
                    error_d  = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
`endif
            end
            S_LOAD: begin
                overrun_d = overrun_q | i_rx_valid;
                ld_idx_d  = ld_idx_q + 1'b1;
`ifdef SEQ_TIMEOUT_EN
                tmr_d     = '0;
`endif
                if (ld_idx_q == LD_LAST) begin
                    ld_idx_d = '0;
                    state_d  = S_WAIT_FFT;
                end
            end
            S_WAIT_FFT: begin
                overrun_d = overrun_q | i_rx_valid;
                if (i_fft_done) begin
                    snap_we  = 1'b1;
                    tx_idx_d = '0;
                    state_d  = S_SEND;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (tmr_q == FFT_TO_LAST) begin
                    rx_cnt_d = '0;
                    tmr_d    = '0;
                    error_d  = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
`endif
            end
            S_SEND: begin
                overrun_d = overrun_q | i_rx_valid;
                state_d   = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                overrun_d = overrun_q | i_rx_valid;
                if (i_tx_done) begin
                    if (tx_idx_q == TX_LAST) begin
                        tx_idx_d = '0;
                        rx_cnt_d = '0;
                        done_d   = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        tx_idx_d = tx_idx_q + 1'b1;
                        state_d  = S_SEND;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state, counters and sticky flags.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q   <= S_IDLE;
            rx_cnt_q  <= '0;
            ld_idx_q  <= '0;
            tx_idx_q  <= '0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_cnt_q  <= rx_cnt_d;
            ld_idx_q  <= ld_idx_d;
            tx_idx_q  <= tx_idx_d;
            overrun_q <= overrun_d;
            done_q    <= done_d;
        end
    end

    // Sample buffer and FFT snapshot; always written before being read.
    always_ff @(posedge i_clk) begin
        if (frame_we) begin
            frame_q[frame_waddr] <= i_rx_byte;
        end
        if (snap_we) begin
            snap_q <= i_fft_re;
        end
    end

    assign tx_phase     = (state_q == S_SEND) || (state_q == S_WAIT_TX);
    assign o_busy       = (state_q != S_IDLE);
    assign o_fft_rst    = (state_q == S_LOAD) || (state_q == S_WAIT_FFT);
    assign o_fft_valid  = (state_q == S_LOAD);
    assign o_fft_byte   = o_fft_valid ? frame_q[ld_idx_q] : '0;
    assign o_tx_start   = (state_q == S_SEND);
    assign o_tx_byte    = tx_phase ?
        snap_q[int'(tx_idx_q)*DATA_LENGTH +: DATA_LENGTH] : '0;
    assign o_frame_done = done_q;
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: scoreboard bench for fft_frame_sequencer.
// Timeout scenario runs only when SEQ_TIMEOUT_EN is defined.
module tb_fft_frame_sequencer;

    localparam int N = 16;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           rx_valid = 1'b0;
    logic [7:0]     rx_byte = '0;
    logic           fft_done = 1'b0;
    logic [N*W-1:0] fft_re = '0;
    logic           tx_done = 1'b0;

    logic       o_fft_rst, o_fft_valid, o_tx_start, o_busy;
    logic       o_frame_done, o_overrun, o_error;
    logic [7:0] o_fft_byte, o_tx_byte;

    int checks = 0;
    int failures = 0;
    int tx_start_cnt = 0;
    int frame_done_cnt = 0;
    int spur_req = 0;
    bit exp_ovr = 1'b0;
    bit exp_err = 1'b0;

    logic [7:0] exp_fft_q [$];
    logic [7:0] exp_tx_q [$];

    fft_frame_sequencer #(
        .FFT_SIZE(N), .WORD_SIZE(W), .DATA_LENGTH(8),
        .RX_TIMEOUT(100), .FFT_TIMEOUT(1024)
    ) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_rx_valid(rx_valid), .i_rx_byte(rx_byte),
        .o_fft_rst(o_fft_rst), .o_fft_valid(o_fft_valid),
        .o_fft_byte(o_fft_byte), .i_fft_done(fft_done),
        .i_fft_re(fft_re), .o_tx_start(o_tx_start),
        .o_tx_byte(o_tx_byte), .i_tx_done(tx_done),
        .o_busy(o_busy), .o_frame_done(o_frame_done),
        .o_overrun(o_overrun), .o_error(o_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a byte.
    initial begin : mon
        int run;
        bit prev;
        bit tx_pending;
        logic [7:0] cur;
        run = 0; prev = 0; tx_pending = 0; cur = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run = 0; prev = 0; tx_pending = 0;
            end else begin
                if (o_fft_valid) begin
                    if (exp_fft_q.size() == 0)
                        chk("fft_expected_pending", 0, 1);
                    else
                        chk("fft_byte", o_fft_byte, exp_fft_q.pop_front());
                    chk("fft_rst_in_load", o_fft_rst, 1);
                    run++;
                end else if (prev) begin
                    chk("fft_run_len", run, N);
                    run = 0;
                end
                prev = o_fft_valid;
                if (tx_pending && tx_done) begin
                    chk("tx_byte_hold", o_tx_byte, cur);
                    tx_pending = 0;
                end
                if (o_tx_start) begin
                    tx_start_cnt++;
                    if (exp_tx_q.size() == 0) begin
                        chk("tx_expected_pending", 0, 1);
                    end else begin
                        cur = exp_tx_q.pop_front();
                        chk("tx_byte", o_tx_byte, cur);
                        tx_pending = 1;
                    end
                end
                if (o_frame_done) frame_done_cnt++;
            end
        end
    end

    // UART_TX model: answers each start with a done two cycles later.
    initial begin : txm
        int ack;
        ack = 0;
        forever begin
            @(negedge clk);
            if (rst_n && o_tx_start) begin
                @(posedge clk);
                @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end else if (spur_req != ack) begin
                ack = spur_req;
                @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1 rx_valid = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        exp_fft_q.delete();
        exp_tx_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b0;
        rx_valid = 1'b0;
        fft_done = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_fft_rst"}, o_fft_rst, 0);
        chk({tag, "_fft_valid"}, o_fft_valid, 0);
        chk({tag, "_fft_byte"}, o_fft_byte, 0);
        chk({tag, "_tx_start"}, o_tx_start, 0);
        chk({tag, "_tx_byte"}, o_tx_byte, 0);
        chk({tag, "_frame_done"}, o_frame_done, 0);
        chk({tag, "_overrun"}, o_overrun, 0);
        chk({tag, "_error"}, o_error, 0);
    endtask

    task automatic run_frame(input logic [7:0] base, input bit spur,
                             input bit ovr, input int abort_tx);
        int c0, fd0, n;
        c0 = tx_start_cnt;
        fd0 = frame_done_cnt;
        for (int i = 0; i < N; i++) exp_fft_q.push_back(base + 8'(i));
        for (int i = 0; i < N; i++) begin
            send_byte(base + 8'(i));
            if (spur && i == 2) begin
                @(posedge clk);
                #1 fft_done = 1'b1;
                @(posedge clk);
                #1 fft_done = 1'b0;
                @(negedge clk);
                chk("spur_done_busy", o_busy, 1);
                chk("spur_done_fft_rst", o_fft_rst, 0);
                chk("spur_done_tx_start", o_tx_start, 0);
            end
        end
        @(negedge clk);
        chk("load_latency", o_fft_valid, 1);
        n = 0;
        while (o_fft_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("load_cycles", n, N);
        chk("wait_fft_rst", o_fft_rst, 1);
        chk("wait_fft_busy", o_busy, 1);
        if (spur) begin
            spur_req++;
            repeat (4) @(negedge clk);
            chk("spur_txd_fft_rst", o_fft_rst, 1);
            chk("spur_txd_tx_start", o_tx_start, 0);
        end
        for (int k = 0; k < N; k++) begin
            fft_re[k*W +: W] = {base, 8'(k)};
            exp_tx_q.push_back(8'(k));
            exp_tx_q.push_back(base);
        end
        @(posedge clk);
        #1 fft_done = 1'b1;
        @(posedge clk);
        #1 fft_done = 1'b0;
        @(negedge clk);
        chk("tx_start_latency", o_tx_start, 1);
        chk("send_fft_rst", o_fft_rst, 0);
        if (ovr) begin
            n = 0;
            while (tx_start_cnt - c0 < 3 && n < 500) begin
                @(negedge clk);
                n++;
            end
            for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i));
            chk("overrun_set", o_overrun, 1);
        end
        if (abort_tx > 0) begin
            n = 0;
            while (tx_start_cnt - c0 < abort_tx && n < 2000) begin
                @(negedge clk);
                n++;
            end
            chk("abort_reach", tx_start_cnt - c0, abort_tx);
            do_reset();
            check_zero("abort");
            repeat (60) @(negedge clk);
            chk("abort_no_tx", tx_start_cnt - c0, abort_tx);
            chk("abort_no_done", frame_done_cnt, fd0);
            return;
        end
        n = 0;
        while (frame_done_cnt == fd0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done_seen", frame_done_cnt - fd0, 1);
        chk("frame_idle", o_busy, 0);
        repeat (4) @(negedge clk);
        chk("frame_tx_count", tx_start_cnt - c0, 2 * N);
        chk("frame_done_once", frame_done_cnt - fd0, 1);
        chk("tx_queue_empty", exp_tx_q.size(), 0);
        chk("overrun_state", o_overrun, exp_ovr);
        chk("error_state", o_error, exp_err);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        check_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_frame(8'h01, 0, 0, 0);
        run_frame(8'h20, 1, 0, 0);

        exp_ovr = 1'b1;
        run_frame(8'h40, 0, 1, 0);
        run_frame(8'h60, 0, 0, 0);

        for (int i = 0; i < 7; i++) send_byte(8'h55);
        do_reset();
        check_zero("midrx");
        exp_ovr = 1'b0;
        run_frame(8'h80, 0, 0, 0);

        run_frame(8'h90, 0, 0, 10);
        run_frame(8'hC0, 0, 0, 0);

`ifdef SEQ_TIMEOUT_EN
        for (int i = 0; i < 5; i++) send_byte(8'h33);
        repeat (99) @(posedge clk);
        @(negedge clk);
        chk("to_still_busy", o_busy, 1);
        chk("to_no_err_yet", o_error, 0);
        @(posedge clk);
        @(negedge clk);
        chk("to_idle", o_busy, 0);
        chk("to_error", o_error, 1);
        exp_err = 1'b1;
        run_frame(8'hE0, 0, 0, 0);
`endif

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Synchronous controller that sequences one FFT frame end to end: collects FFT_SIZE received UART bytes, streams them into the FFT core, captures the real outputs, and serializes them as 2·FFT_SIZE bytes to the UART transmitter. It sits between UART_RX, FFT_for_OFDM and UART_TX in the top level. It replaces the edge-triggered done/start glue with a single-clock FSM.

## Interface
- FFT_SIZE, 16, points per frame (power of two, ≥4)
- WORD_SIZE, 16, bits per FFT real output
- DATA_LENGTH, 8, bits per UART byte (WORD_SIZE = 2·DATA_LENGTH)
- RX_TIMEOUT, 86800, max idle cycles between bytes inside a partial frame
- FFT_TIMEOUT, 1024, max cycles waiting for FFT done

Ports:
- i_clk  in  1  single clock, all logic on rising edge
- i_rst  in  1  synchronous, active-low reset
- i_rx_valid  in  1  one-cycle pulse, new received byte
- i_rx_byte  in  DATA_LENGTH  received byte, valid with i_rx_valid
- o_fft_rst  out  1  active-low reset to FFT core
- o_fft_valid  out  1  byte strobe into FFT core
- o_fft_byte  out  DATA_LENGTH  sample to FFT core
- i_fft_done  in  1  one-cycle pulse, FFT outputs valid
- i_fft_re  in  FFT_SIZE·WORD_SIZE  flattened real outputs, bin k at [k·WORD_SIZE +: WORD_SIZE]
- o_tx_start  out  1  one-cycle start pulse to UART_TX
- o_tx_byte  out  DATA_LENGTH  byte to transmit
- i_tx_done  in  1  one-cycle pulse, byte sent
- o_busy  out  1  high in any state but IDLE
- o_frame_done  out  1  one-cycle pulse after final byte's i_tx_done
- o_overrun  out  1  sticky: byte dropped while busy past COLLECT
- o_error  out  1  sticky: timeout abort

## Operation
- States: IDLE, COLLECT, LOAD, WAIT_FFT, SEND, WAIT_TX.
- IDLE: i_rx_valid writes buf[0], rx_cnt=1, → COLLECT.
- COLLECT: each i_rx_valid writes buf[rx_cnt], rx_cnt+1; writing index FFT_SIZE−1 → LOAD next cycle.
- LOAD: o_fft_rst=1; o_fft_valid=1 for FFT_SIZE consecutive cycles, o_fft_byte=buf[0..FFT_SIZE−1] in order; then → WAIT_FFT.
- WAIT_FFT: on i_fft_done, capture i_fft_re into snapshot register same edge, tx_idx=0, → SEND.
- SEND: o_tx_start=1 one cycle, o_tx_byte=snapshot byte tx_idx (even idx = low byte of bin idx/2, odd = high byte), → WAIT_TX.
- WAIT_TX: on i_tx_done, if tx_idx=2·FFT_SIZE−1 → IDLE with o_frame_done pulse; else tx_idx+1, → SEND.
- o_fft_rst=0 in every state except LOAD/WAIT_FFT (FFT held in reset otherwise).
- o_tx_byte held stable from SEND through WAIT_TX.
- i_rx_valid in LOAD/WAIT_FFT/SEND/WAIT_TX: byte discarded, o_overrun set; no state change.
- i_fft_done outside WAIT_FFT and i_tx_done outside WAIT_TX ignored.
- Counters wrap never: rx_cnt ≤ FFT_SIZE, tx_idx ≤ 2·FFT_SIZE−1 by construction.

## Timing
- Reset (i_rst=0 at edge): state IDLE, counters 0, all outputs 0 (o_fft_rst=0, o_tx_start=0, o_overrun=0, o_error=0); buf/snapshot contents undefined. Reset mid-frame aborts immediately, no partial TX.
- Last rx byte at edge N → LOAD at N+1, first o_fft_valid cycle N+1, last N+FFT_SIZE, WAIT_FFT from N+FFT_SIZE+1.
- i_fft_done at edge M → o_tx_start high cycle M+1.
- i_tx_done at edge T (not last) → next o_tx_start at T+1.
- Frame output: exactly 2·FFT_SIZE o_tx_start pulses, then one o_frame_done.
- o_overrun/o_error clear only by reset.

## Configuration
- SEQ_TIMEOUT_EN defined: COLLECT with no i_rx_valid for RX_TIMEOUT cycles → IDLE, partial frame discarded, o_error set; WAIT_FFT without i_fft_done for FFT_TIMEOUT cycles → IDLE, o_error set. Timer restarts on each accepted byte / on LOAD exit.
- Not defined: no timers; COLLECT and WAIT_FFT wait indefinitely; o_error tied 0.

## Test plan
- 16 bytes 0x01..0x10, model FFT returns bin k = 0x0100+k → 32 tx bytes 0x00,0x01,0x01,0x01,…,0x0F,0x01 in order, one o_frame_done, o_overrun=0.
- Check LOAD: o_fft_valid high exactly 16 consecutive cycles, o_fft_byte 0x01..0x10, o_fft_rst high from first LOAD cycle until WAIT_FFT exit.
- Send 3 extra bytes during WAIT_TX → ignored, o_overrun=1, TX sequence unchanged; next frame processes normally.
- Assert i_rst=0 after 7 bytes and again during byte 10 of TX → IDLE next cycle, o_tx_start never pulses afterward, all outputs 0.
- SEQ_TIMEOUT_EN, RX_TIMEOUT=100: 5 bytes then 100 idle cycles → IDLE, o_error=1; next 16 bytes form a full clean frame.
- Spurious i_fft_done in COLLECT and i_tx_done in WAIT_FFT → no state change.
